// File: rtl/axis_frame_arbiter.sv
// Round-robin arbiter: K framed source streams share one N-bit output stream; the grant is held per frame allowance.
// Optional orphan-beat drain when AXIS_FRAME_ARB_DROP_ORPHAN_EN is defined (default build: orphans stall, drop_count = 0).
module axis_frame_arbiter #(
  parameter int K                = 4,
  parameter int N                = 24,
  parameter int FRAMES_PER_GRANT = 1,
  parameter int W_K              = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K*N-1:0] s_axis_tdata,
  input  logic [K-1:0]   s_axis_tfirst,
  input  logic [K-1:0]   s_axis_tvalid,
  output logic [K-1:0]   s_axis_tnext,
  output logic [N-1:0]   m_axis_tdata,
  output logic           m_axis_tfirst,
  output logic           m_axis_tvalid,
  input  logic           m_axis_tnext,
  output logic           grant_valid,
  output logic [W_K-1:0] grant_idx,
  output logic [15:0]    frame_count,
  output logic [15:0]    drop_count
);

  // state   | meaning
  // ST_IDLE | no owner; round-robin search over frame starts after r_rr_ptr
  // ST_GRANT| r_grant_idx owns the output until it starts a frame past its allowance
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t         r_state, w_state_nxt;
  logic [W_K-1:0] r_grant_idx, w_grant_idx_nxt;
  logic [W_K-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [7:0]     r_frm_cnt, w_frm_cnt_nxt;
  logic [15:0]    r_frame_count;

  logic           w_pick_found;
  logic [W_K-1:0] w_pick;
  logic [K-1:0]   w_grant_mask;
  logic           w_in_grant;
  logic           w_g_valid;
  logic           w_g_first;
  logic           w_end_cond;
  logic           w_m_tvalid;
  logic           w_m_xfer;
  logic [K-1:0]   w_s_tnext;

  always_comb begin
    int             w_idx_int;
    logic [W_K-1:0] w_idx;
    w_pick_found = 1'b0;
    w_pick       = '0;
    for (int off = 1; off <= K; off++) begin
      w_idx_int = int'(r_rr_ptr) + off;
      if (w_idx_int >= K) w_idx_int = w_idx_int - K;
      w_idx = W_K'(w_idx_int);
      if (!w_pick_found && s_axis_tvalid[w_idx] && s_axis_tfirst[w_idx]) begin
        w_pick_found = 1'b1;
        w_pick       = w_idx;
      end
    end
  end

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_g_valid  = s_axis_tvalid[r_grant_idx];
  assign w_g_first  = s_axis_tfirst[r_grant_idx];
  assign w_end_cond = w_in_grant && w_g_valid && w_g_first &&
                      (r_frm_cnt == 8'(FRAMES_PER_GRANT));
  assign w_m_tvalid = w_in_grant && w_g_valid && !w_end_cond;
  assign w_m_xfer   = w_m_tvalid && m_axis_tnext;

  always_comb begin
    w_grant_mask              = '0;
    w_grant_mask[r_grant_idx] = w_in_grant;
  end

`ifdef AXIS_FRAME_ARB_DROP_ORPHAN_EN
  logic [K-1:0]   w_drain;
  logic [W_K:0]   w_drop_inc;
  logic [16:0]    w_drop_sum;
  logic [15:0]    r_drop_count;

  // Held low during reset so no beat is drained while the block is in reset.
  assign w_drain = s_axis_tvalid & ~s_axis_tfirst & ~w_grant_mask & {K{rst}};

  always_comb begin
    w_drop_inc = '0;
    for (int i = 0; i < K; i++) w_drop_inc = w_drop_inc + {{W_K{1'b0}}, w_drain[i]};
  end

  assign w_drop_sum = {1'b0, r_drop_count} + {{(16 - W_K){1'b0}}, w_drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_drop_count <= '0;
    else      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign w_s_tnext  = (w_grant_mask & {K{w_m_xfer}}) | w_drain;
  assign drop_count = r_drop_count;
`else
  assign w_s_tnext  = w_grant_mask & {K{w_m_xfer}};
  assign drop_count = '0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_frm_cnt_nxt   = r_frm_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt     = ST_GRANT;
          w_grant_idx_nxt = w_pick;
          w_frm_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_end_cond) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = r_grant_idx;
        end else if (w_m_xfer && w_g_first) begin
          w_frm_cnt_nxt = r_frm_cnt + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= W_K'(K - 1);
      r_frm_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_frm_cnt   <= w_frm_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_frame_count <= '0;
    else if (w_m_xfer && w_g_first)   r_frame_count <= r_frame_count + 16'd1;
  end

  assign m_axis_tdata  = s_axis_tdata[int'(r_grant_idx)*N +: N];
  assign m_axis_tfirst = w_g_first;
  assign m_axis_tvalid = w_m_tvalid;
  assign s_axis_tnext  = w_s_tnext;
  assign grant_valid   = w_in_grant;
  assign grant_idx     = r_grant_idx;
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: two instances (allowance 1 and 2) checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_axis_frame_arbiter;
  localparam int K   = 4;
  localparam int N   = 24;
  localparam int W_K = 2;
`ifdef AXIS_FRAME_ARB_DROP_ORPHAN_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [K*N-1:0] s_tdata  [2];
  logic [K-1:0]   s_tfirst [2];
  logic [K-1:0]   s_tvalid [2];
  logic [K-1:0]   s_tnext  [2];
  logic [N-1:0]   m_tdata  [2];
  logic           m_tfirst [2];
  logic           m_tvalid [2];
  logic           m_tnext  [2];
  logic           gv       [2];
  logic [W_K-1:0] gi       [2];
  logic [15:0]    fc       [2];
  logic [15:0]    dc       [2];

  axis_frame_arbiter #(.K(K), .N(N), .FRAMES_PER_GRANT(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[0]), .s_axis_tfirst(s_tfirst[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tnext(s_tnext[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tfirst(m_tfirst[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tnext(m_tnext[0]),
    .grant_valid(gv[0]), .grant_idx(gi[0]), .frame_count(fc[0]), .drop_count(dc[0])
  );

  axis_frame_arbiter #(.K(K), .N(N), .FRAMES_PER_GRANT(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[1]), .s_axis_tfirst(s_tfirst[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tnext(s_tnext[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tfirst(m_tfirst[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tnext(m_tnext[1]),
    .grant_valid(gv[1]), .grant_idx(gi[1]), .frame_count(fc[1]), .drop_count(dc[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // source beat queues, entry = {tfirst, tdata}; index d*K+src
  logic [N:0] srcq [2*K][$];
  logic [K-1:0] xfer [2];
  int tn_mode [2];
  int gap_pct = 0;

  // model: current owner (-1 = none), frames started in this grant, round-robin pointer
  int m_owner [2];
  int m_cnt   [2];
  int m_rrp   [2];
  int m_gidx  [2];
  int m_fc    [2];
  int m_dc    [2];

  // log of accepted output beats
  int log_data  [2][$];
  int log_first [2][$];
  int log_src   [2][$];
  int log_cyc   [2][$];

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int d);
    m_owner[d] = -1;
    m_cnt[d]   = 0;
    m_rrp[d]   = K - 1;
    m_gidx[d]  = 0;
    m_fc[d]    = 0;
    m_dc[d]    = 0;
  endtask

  task automatic eval_cycle(input int d);
    logic [K-1:0] v, f, drain, exp_tn;
    int g, pick;
    bit endc, mv, xf;
    v = s_tvalid[d];
    f = s_tfirst[d];
    if (!rst) begin
      chk(d, "rst m_tvalid", m_tvalid[d], 0);
      chk(d, "rst s_tnext", s_tnext[d], 0);
      chk(d, "rst grant_valid", gv[d], 0);
      chk(d, "rst grant_idx", gi[d], 0);
      chk(d, "rst frame_count", fc[d], 0);
      chk(d, "rst drop_count", dc[d], 0);
      model_reset(d);
      for (int i = 0; i < K; i++) srcq[d*K+i].delete();
      s_tvalid[d] = '0;
      s_tfirst[d] = '0;
      xfer[d]     = '0;
      return;
    end
    drain  = DROP_EN ? (v & ~f) : '0;
    exp_tn = '0;
    mv     = 1'b0;
    endc   = 1'b0;
    pick   = -1;
    g      = 0;
    if (m_owner[d] < 0) begin
      for (int off = 1; off <= K; off++) begin
        int j;
        j = (m_rrp[d] + off) % K;
        if (pick < 0 && v[j] && f[j]) pick = j;
      end
    end else begin
      g        = m_owner[d];
      endc     = v[g] && f[g] && (m_cnt[d] == d + 1);
      mv       = v[g] && !endc;
      drain[g] = 1'b0;
      exp_tn[g] = mv && m_tnext[d];
    end
    exp_tn = exp_tn | drain;
    xf     = mv && m_tnext[d];

    chk(d, "m_tvalid", m_tvalid[d], mv);
    if (mv) begin
      chk(d, "m_tdata", m_tdata[d], s_tdata[d][g*N +: N]);
      chk(d, "m_tfirst", m_tfirst[d], f[g]);
    end
    chk(d, "s_tnext", s_tnext[d], exp_tn);
    chk(d, "grant_valid", gv[d], m_owner[d] >= 0);
    chk(d, "grant_idx", gi[d], m_gidx[d]);
    chk(d, "frame_count", fc[d], m_fc[d]);
    chk(d, "drop_count", dc[d], m_dc[d]);

    if (m_tvalid[d] === 1'b1 && m_tnext[d] === 1'b1) begin
      log_data[d].push_back(int'(m_tdata[d]));
      log_first[d].push_back(int'(m_tfirst[d]));
      log_src[d].push_back(int'(gi[d]));
      log_cyc[d].push_back(cyc);
    end
    xfer[d] = v & s_tnext[d];

    if (xf && f[g]) begin
      m_fc[d]  = (m_fc[d] + 1) % 65536;
      m_cnt[d] = m_cnt[d] + 1;
    end
    m_dc[d] = m_dc[d] + $countones(drain);
    if (m_dc[d] > 65535) m_dc[d] = 65535;
    if (m_owner[d] < 0 && pick >= 0) begin
      m_owner[d] = pick;
      m_gidx[d]  = pick;
      m_cnt[d]   = 0;
    end else if (m_owner[d] >= 0 && endc) begin
      m_rrp[d]   = g;
      m_owner[d] = -1;
    end
  endtask

  task automatic drive(input int d);
    if (!rst) return;
    case (tn_mode[d])
      0:       m_tnext[d] = 1'b1;
      1:       m_tnext[d] = ~m_tnext[d];
      default: m_tnext[d] = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < K; i++) begin
      int q;
      q = d*K + i;
      if (xfer[d][i]) begin
        void'(srcq[q].pop_front());
        s_tvalid[d][i] = 1'b0;
      end
      if (!s_tvalid[d][i] && srcq[q].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        s_tvalid[d][i]         = 1'b1;
        s_tfirst[d][i]         = srcq[q][0][N];
        s_tdata[d][i*N +: N]   = srcq[q][0][N-1:0];
      end
    end
  endtask

  initial begin : cycle_proc
    for (int d = 0; d < 2; d++) begin
      s_tdata[d]  = '0;
      s_tfirst[d] = '0;
      s_tvalid[d] = '0;
      m_tnext[d]  = 1'b1;
      xfer[d]     = '0;
      tn_mode[d]  = 0;
      model_reset(d);
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) eval_cycle(d);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) drive(d);
    end
  end

  task automatic push_frame(input int d, input int src, input int len, input int base);
    logic [N:0] e;
    for (int b = 0; b < len; b++) begin
      e = {(b == 0), N'(base + b)};
      srcq[d*K+src].push_back(e);
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      log_data[d].delete();
      log_first[d].delete();
      log_src[d].delete();
      log_cyc[d].delete();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_beats(input int d, input int n, input int budget, input string name);
    int t;
    t = 0;
    while (log_data[d].size() < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (log_data[d].size() < n) begin
      checks++;
      errors++;
      $display("FAIL dut%0d %s timeout: got %0d beats expected %0d", d, name, log_data[d].size(), n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0;
    int exp_src [5];
    int exp_base [5];
    exp_src  = '{0, 1, 2, 3, 0};
    exp_base = '{'h000, 'h100, 'h200, 'h300, 'h010};

    // single 3-beat frame from source 2
    apply_reset();
    chk(0, "post-reset grant_valid", gv[0], 0);
    @(negedge clk); #1;
    c0 = cyc;
    push_frame(0, 2, 3, 'h200);
    wait_beats(0, 3, 50, "t1");
    if (log_data[0].size() >= 3) begin
      chk(0, "t1 first beat cycle", log_cyc[0][0], c0 + 2);
      for (int b = 0; b < 3; b++) begin
        chk(0, "t1 data", log_data[0][b], 'h200 + b);
        chk(0, "t1 first", log_first[0][b], (b == 0));
        chk(0, "t1 src", log_src[0][b], 2);
      end
    end
    @(posedge clk); #2;
    chk(0, "t1 frame_count", fc[0], 1);
    chk(0, "t1 grant_idx", gi[0], 2);
    chk(0, "t1 grant_valid held", gv[0], 1);

    // all sources continuous 4-beat frames, allowance 1
    apply_reset();
    @(negedge clk); #1;
    for (int s = 0; s < K; s++)
      for (int fr = 0; fr < 2; fr++) push_frame(0, s, 4, s*'h100 + fr*'h10);
    wait_beats(0, 20, 300, "t2");
    if (log_data[0].size() >= 20) begin
      for (int k = 0; k < 5; k++) begin
        chk(0, "t2 frame src", log_src[0][4*k], exp_src[k]);
        chk(0, "t2 frame data", log_data[0][4*k], exp_base[k]);
        chk(0, "t2 frame contiguous", log_cyc[0][4*k+3] - log_cyc[0][4*k], 3);
      end
      for (int k = 0; k < 4; k++)
        chk(0, "t2 handover idle cycles", log_cyc[0][4*k+4] - log_cyc[0][4*k+3] - 1, 2);
    end

    // downstream acceptance toggling
    apply_reset();
    tn_mode[0] = 1;
    @(negedge clk); #1;
    push_frame(0, 1, 6, 'h300);
    wait_beats(0, 6, 100, "t3");
    repeat (6) @(posedge clk);
    #2;
    chk(0, "t3 beat count", log_data[0].size(), 6);
    if (log_data[0].size() >= 6)
      for (int b = 0; b < 6; b++) chk(0, "t3 data order", log_data[0][b], 'h300 + b);
    tn_mode[0] = 0;

    // allowance 2: source 1 sends 3 frames, source 3 waits
    apply_reset();
    @(negedge clk); #1;
    push_frame(1, 1, 2, 'h410);
    push_frame(1, 1, 2, 'h420);
    push_frame(1, 1, 2, 'h430);
    push_frame(1, 3, 3, 'h4F0);
    wait_beats(1, 7, 100, "t4");
    if (log_data[1].size() >= 7) begin
      chk(1, "t4 frame a src", log_src[1][0], 1);
      chk(1, "t4 frame b src", log_src[1][2], 1);
      chk(1, "t4 frame b data", log_data[1][2], 'h420);
      chk(1, "t4 a->b no bubble", log_cyc[1][2] - log_cyc[1][1], 1);
      chk(1, "t4 third frame src", log_src[1][4], 3);
      chk(1, "t4 third frame data", log_data[1][4], 'h4F0);
      chk(1, "t4 handover gap", log_cyc[1][4] - log_cyc[1][3], 3);
    end

    // orphan beat on non-granted source 0
    apply_reset();
    @(negedge clk); #1;
    push_frame(0, 1, 4, 'h500);
    wait_beats(0, 1, 50, "t5 grant");
    srcq[0].push_back({1'b0, N'('h5AA)});
    wait_beats(0, 4, 50, "t5");
    repeat (3) @(posedge clk);
    #2;
    chk(0, "t5 drop_count", dc[0], DROP_EN ? 1 : 0);
    chk(0, "t5 orphan still offered", s_tvalid[0][0], DROP_EN ? 0 : 1);
    chk(0, "t5 beats forwarded", log_data[0].size(), 4);

    // asynchronous reset on the third beat of a frame
    apply_reset();
    @(negedge clk); #1;
    push_frame(0, 2, 5, 'h600);
    wait_beats(0, 2, 50, "t6");
    @(posedge clk); #3;
    chk(0, "t6 pre m_tvalid", m_tvalid[0], 1);
    chk(0, "t6 pre frame_count", fc[0], 1);
    rst = 1'b0;
    #1;
    chk(0, "t6 async m_tvalid", m_tvalid[0], 0);
    chk(0, "t6 async grant_valid", gv[0], 0);
    chk(0, "t6 async grant_idx", gi[0], 0);
    chk(0, "t6 async frame_count", fc[0], 0);
    chk(0, "t6 async drop_count", dc[0], 0);
    chk(0, "t6 async s_tnext", s_tnext[0], 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    clear_logs();
    @(negedge clk); #1;
    push_frame(0, 3, 2, 'h630);
    push_frame(0, 0, 2, 'h600);
    wait_beats(0, 2, 50, "t6 restart");
    if (log_data[0].size() >= 2) begin
      chk(0, "t6 restart src", log_src[0][0], 0);
      chk(0, "t6 restart data", log_data[0][0], 'h600);
    end

    // randomized traffic on both instances
    apply_reset();
    tn_mode[0] = 2;
    tn_mode[1] = 2;
    gap_pct    = 30;
    for (int t = 0; t < 1500; t++) begin
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < K; s++)
          if (srcq[d*K+s].size() < 3)
            push_frame(d, s, $urandom_range(1, 6), $urandom_range(0, 'hFFFF));
    end
    repeat (50) @(posedge clk);
    #2;
    chk(0, "random traffic flowed", log_data[0].size() > 200, 1);
    chk(1, "random traffic flowed", log_data[1].size() > 200, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
